// File: rtl/flag_branch_unit.sv
// Flag register plus branch condition/target resolver; 1-cycle result latency, 2 on a flag hazard.
// Decode is stalled one cycle when a branch needs flags still in execute, unless FLAG_FWD_EN forwards them.
module flag_branch_unit #(
  parameter int DW    = 16,
  parameter int IMM_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic [2:0]       alu_flags,
  input  logic             br_valid,
  input  logic             br_is_reg,
  input  logic [2:0]       br_ccc,
  input  logic [DW-1:0]    pc_plus2,
  input  logic [IMM_W-1:0] br_imm,
  input  logic [DW-1:0]    br_reg,
  output logic             stall,
  output logic             res_valid,
  output logic             res_taken,
  output logic [DW-1:0]    res_target,
  output logic [2:0]       flags
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [2:0]       flags_q;
  logic [2:0]       mask;
  logic [2:0]       flags_merged;
  logic             writes_flags;

  logic             h_is_reg;
  logic [2:0]       h_ccc;
  logic [DW-1:0]    h_pc;
  logic [IMM_W-1:0] h_imm;
  logic [DW-1:0]    h_reg;

  logic             stall_c, do_res, capture;
  logic             sel_is_reg;
  logic [2:0]       sel_ccc;
  logic [DW-1:0]    sel_pc, sel_reg, imm_ext, b_target;
  logic [IMM_W-1:0] sel_imm;
  logic [2:0]       eval_flags;
  logic             taken_c;

  function automatic logic cond_eval(input logic [2:0] ccc, input logic [2:0] f);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (ccc)
      3'b000:  cond_eval = ~z;
      3'b001:  cond_eval = z;
      3'b010:  cond_eval = ~z & ~n;
      3'b011:  cond_eval = n;
      3'b100:  cond_eval = z | ~n;
      3'b101:  cond_eval = n | z;
      3'b110:  cond_eval = v;
      default: cond_eval = 1'b1;
    endcase
  endfunction

  always_comb begin
    case (ex_opcode)
      4'b0000, 4'b0001:                   mask = 3'b111;
      4'b0010, 4'b0100, 4'b0101, 4'b0110: mask = 3'b100;
      default:                            mask = 3'b000;
    endcase
  end

  assign writes_flags = ex_valid & (|mask);
  // Masking with AND keeps undriven ALU bits out of the register.
  assign flags_merged = (flags_q & ~mask) | (alu_flags & mask);
  assign flags        = flags_q;

  always_comb begin
    state_d    = state_q;
    stall_c    = 1'b0;
    do_res     = 1'b0;
    capture    = 1'b0;
    sel_is_reg = br_is_reg;
    sel_ccc    = br_ccc;
    sel_pc     = pc_plus2;
    sel_imm    = br_imm;
    sel_reg    = br_reg;
    eval_flags = flags_q;
    case (state_q)
      RUN: begin
        if (br_valid) begin
`ifdef FLAG_FWD_EN
          do_res = 1'b1;
          if (writes_flags) eval_flags = flags_merged;
`else
          if (writes_flags) begin
            stall_c = 1'b1;
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            do_res = 1'b1;
          end
`endif
        end
      end
      HOLD: begin
        do_res     = 1'b1;
        sel_is_reg = h_is_reg;
        sel_ccc    = h_ccc;
        sel_pc     = h_pc;
        sel_imm    = h_imm;
        sel_reg    = h_reg;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign stall    = stall_c & rst_n;
  assign imm_ext  = {{(DW-IMM_W){sel_imm[IMM_W-1]}}, sel_imm};
  assign b_target = sel_pc + {imm_ext[DW-2:0], 1'b0};
  assign taken_c  = cond_eval(sel_ccc, eval_flags);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      flags_q    <= 3'b000;
      res_valid  <= 1'b0;
      res_taken  <= 1'b0;
      res_target <= '0;
      h_is_reg   <= 1'b0;
      h_ccc      <= 3'b000;
      h_pc       <= '0;
      h_imm      <= '0;
      h_reg      <= '0;
    end else begin
      state_q   <= state_d;
      res_valid <= do_res;
      if (writes_flags) flags_q <= flags_merged;
      if (do_res) begin
        res_taken  <= taken_c;
        res_target <= taken_c ? (sel_is_reg ? sel_reg : b_target) : sel_pc;
      end
      if (capture) begin
        h_is_reg <= br_is_reg;
        h_ccc    <= br_ccc;
        h_pc     <= pc_plus2;
        h_imm    <= br_imm;
        h_reg    <= br_reg;
      end
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: vector table plus hazard / reset-in-HOLD sequences, scoreboarded results.
module tb_flag_branch_unit;

  logic        clk, rst_n;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [2:0]  alu_flags;
  logic        br_valid, br_is_reg;
  logic [2:0]  br_ccc;
  logic [15:0] pc_plus2, br_reg;
  logic [8:0]  br_imm;
  logic        stall, res_valid, res_taken;
  logic [15:0] res_target;
  logic [2:0]  flags;

  flag_branch_unit #(.DW(16), .IMM_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .alu_flags(alu_flags), .br_valid(br_valid), .br_is_reg(br_is_reg),
    .br_ccc(br_ccc), .pc_plus2(pc_plus2), .br_imm(br_imm), .br_reg(br_reg),
    .stall(stall), .res_valid(res_valid), .res_taken(res_taken),
    .res_target(res_target), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        exv;
    logic [3:0]  op;
    logic [2:0]  alu;
    logic        brv;
    logic        isreg;
    logic [2:0]  ccc;
    logic [15:0] pc;
    logic [8:0]  imm;
    logic [15:0] breg;
    logic [2:0]  eflags;
    logic        etaken;
    logic [15:0] etarget;
  } vec_t;

  typedef struct {
    int          due;
    logic        taken;
    logic [15:0] target;
  } exp_t;

  localparam int NV = 22;
  vec_t tbl[NV];
  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  function automatic vec_t mk(input logic exv, input logic [3:0] op, input logic [2:0] alu,
                              input logic brv, input logic isreg, input logic [2:0] ccc,
                              input logic [15:0] pc, input logic [8:0] imm, input logic [15:0] breg,
                              input logic [2:0] eflags, input logic etaken, input logic [15:0] etarget);
    vec_t v;
    v.exv = exv; v.op = op; v.alu = alu; v.brv = brv; v.isreg = isreg; v.ccc = ccc;
    v.pc = pc; v.imm = imm; v.breg = breg; v.eflags = eflags; v.etaken = etaken; v.etarget = etarget;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int due, input logic t, input logic [15:0] tg);
    exp_t e;
    e.due = due; e.taken = t; e.target = tg;
    sbq.push_back(e);
  endtask

  task automatic drive(input vec_t v);
    ex_valid = v.exv; ex_opcode = v.op; alu_flags = v.alu;
    br_valid = v.brv; br_is_reg = v.isreg; br_ccc = v.ccc;
    pc_plus2 = v.pc; br_imm = v.imm; br_reg = v.breg;
  endtask

  task automatic idle();
    ex_valid = 0; ex_opcode = 4'hF; alu_flags = 0; br_valid = 0; br_is_reg = 0;
    br_ccc = 0; pc_plus2 = 0; br_imm = 0; br_reg = 0;
  endtask

  // Advance one clock and reconcile res_valid against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (res_valid) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_res_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("res_due_cycle", cyc, e.due);
        chk("res_taken", {31'b0, res_taken}, {31'b0, e.taken});
        chk("res_target", {16'b0, res_target}, {16'b0, e.target});
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      checks++; failures++;
      $display("FAIL missing_res_valid: got 0 expected 1 due cycle %0d (cycle %0d)", e.due, cyc);
    end
  endtask

  initial begin
    //              exv op     alu    brv reg ccc     pc        imm     breg      flags  tk  target
    tbl[0]  = mk(1, 4'b0000, 3'b100, 0, 0, 3'b000, 16'h0000, 9'h000, 16'h0000, 3'b100, 0, 16'h0000);
    tbl[1]  = mk(0, 4'b0000, 3'b000, 0, 0, 3'b000, 16'h0000, 9'h000, 16'h0000, 3'b100, 0, 16'h0000);
    tbl[2]  = mk(0, 4'b0000, 3'b000, 1, 0, 3'b001, 16'h0010, 9'h1FE, 16'h0000, 3'b100, 1, 16'h000C);
    tbl[3]  = mk(0, 4'b0000, 3'b000, 1, 0, 3'b000, 16'h0020, 9'h004, 16'h0000, 3'b100, 0, 16'h0020);
    tbl[4]  = mk(1, 4'b0001, 3'b011, 0, 0, 3'b000, 16'h0000, 9'h000, 16'h0000, 3'b011, 0, 16'h0000);
    tbl[5]  = mk(0, 4'b0000, 3'b000, 1, 0, 3'b010, 16'h0100, 9'h010, 16'h0000, 3'b011, 0, 16'h0100);
    tbl[6]  = mk(0, 4'b0000, 3'b000, 1, 0, 3'b011, 16'h0100, 9'h010, 16'h0000, 3'b011, 1, 16'h0120);
    tbl[7]  = mk(1, 4'b0010, 3'b100, 0, 0, 3'b000, 16'h0000, 9'h000, 16'h0000, 3'b111, 0, 16'h0000);
    tbl[8]  = mk(1, 4'b0111, 3'bxxx, 1, 0, 3'b110, 16'h0200, 9'h1F0, 16'h0000, 3'b111, 1, 16'h01E0);
    tbl[9]  = mk(0, 4'b0000, 3'b000, 1, 1, 3'b111, 16'h1234, 9'h000, 16'hBEEF, 3'b111, 1, 16'hBEEF);
    tbl[10] = mk(1, 4'b0000, 3'b000, 0, 0, 3'b000, 16'h0000, 9'h000, 16'h0000, 3'b000, 0, 16'h0000);
    tbl[11] = mk(0, 4'b0000, 3'b000, 1, 0, 3'b100, 16'h0030, 9'h0FF, 16'h0000, 3'b000, 1, 16'h022E);
    tbl[12] = mk(0, 4'b0000, 3'b000, 1, 0, 3'b101, 16'h0030, 9'h0FF, 16'h0000, 3'b000, 0, 16'h0030);
    tbl[13] = mk(1, 4'b0100, 3'b111, 0, 0, 3'b000, 16'h0000, 9'h000, 16'h0000, 3'b100, 0, 16'h0000);
    tbl[14] = mk(1, 4'b0000, 3'b011, 0, 0, 3'b000, 16'h0000, 9'h000, 16'h0000, 3'b011, 0, 16'h0000);
    tbl[15] = mk(1, 4'b0101, 3'b000, 0, 0, 3'b000, 16'h0000, 9'h000, 16'h0000, 3'b011, 0, 16'h0000);
    tbl[16] = mk(1, 4'b0110, 3'b110, 0, 0, 3'b000, 16'h0000, 9'h000, 16'h0000, 3'b111, 0, 16'h0000);
    tbl[17] = mk(1, 4'b1111, 3'b000, 0, 0, 3'b000, 16'h0000, 9'h000, 16'h0000, 3'b111, 0, 16'h0000);
    tbl[18] = mk(0, 4'b0000, 3'b000, 1, 0, 3'b111, 16'hFFFE, 9'h002, 16'h0000, 3'b111, 1, 16'h0002);
    tbl[19] = mk(0, 4'b0000, 3'b000, 1, 1, 3'b110, 16'h0008, 9'h000, 16'h0ABC, 3'b111, 1, 16'h0ABC);
    tbl[20] = mk(0, 4'b0000, 3'b000, 1, 0, 3'b000, 16'h0050, 9'h004, 16'h0000, 3'b111, 0, 16'h0050);
    tbl[21] = mk(0, 4'b0000, 3'b000, 1, 1, 3'b010, 16'h0060, 9'h000, 16'h1111, 3'b111, 0, 16'h0060);

    // Reset, with a hazard-shaped input pattern that must not raise stall.
    rst_n = 1'b1;
    idle();
    #1;
    rst_n = 1'b0;
    ex_valid = 1; ex_opcode = 4'b0000; alu_flags = 3'b111; br_valid = 1;
    #2;
    chk("rst_stall", {31'b0, stall}, 0);
    #5;
    chk("rst_flags", {29'b0, flags}, 0);
    chk("rst_res_valid", {31'b0, res_valid}, 0);
    chk("rst_res_taken", {31'b0, res_taken}, 0);
    chk("rst_res_target", {16'b0, res_target}, 0);
    chk("rst_stall_after_edge", {31'b0, stall}, 0);
    idle();
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_flags", {29'b0, flags}, 0);
      chk("idle_res_target", {16'b0, res_target}, 0);
    end

    // Vector table: no-hazard cases, results due one cycle after the branch.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      if (tbl[i].brv) push_exp(cyc + 1, tbl[i].etaken, tbl[i].etarget);
      @(negedge clk);
      chk($sformatf("row%0d_stall", i), {31'b0, stall}, 0);
      tick();
      chk($sformatf("row%0d_flags", i), {29'b0, flags}, {29'b0, tbl[i].eflags});
    end
    idle();
    tick();
    chk("hold_res_taken", {31'b0, res_taken}, 0);
    chk("hold_res_target", {16'b0, res_target}, 16'h0060);

    // Flag hazard: SUB sets N while LT is in decode.
    ex_valid = 1; ex_opcode = 4'b0000; alu_flags = 3'b000;
    tick();
    chk("haz_pre_flags", {29'b0, flags}, 0);
    ex_valid = 1; ex_opcode = 4'b0001; alu_flags = 3'b001;
    br_valid = 1; br_is_reg = 0; br_ccc = 3'b011; pc_plus2 = 16'h0060; br_imm = 9'h002;
    push_exp(FWD ? cyc + 1 : cyc + 2, 1'b1, 16'h0064);
    @(negedge clk);
    chk("haz_stall", {31'b0, stall}, FWD ? 0 : 1);
    tick();
    chk("haz_flags", {29'b0, flags}, 3'b001);
    // Younger ADD sets Z (clears N); must not change the pending branch decision.
    ex_valid = 1; ex_opcode = 4'b0000; alu_flags = 3'b100;
    br_valid = FWD ? 1'b0 : 1'b1;
    @(negedge clk);
    chk("haz_hold_stall", {31'b0, stall}, 0);
    tick();
    chk("haz_young_flags", {29'b0, flags}, 3'b100);
    idle();
    tick();
    tick();

    // Reset pulsed while a hazarded branch waits in HOLD.
    ex_valid = 1; ex_opcode = 4'b0000; alu_flags = 3'b000;
    br_valid = 1; br_is_reg = 0; br_ccc = 3'b111; pc_plus2 = 16'h0070; br_imm = 9'h000;
    if (FWD) push_exp(cyc + 1, 1'b1, 16'h0070);
    @(negedge clk);
    chk("rhold_stall", {31'b0, stall}, FWD ? 0 : 1);
    tick();
    idle();
    rst_n = 1'b0;
    #2;
    chk("rhold_flags", {29'b0, flags}, 0);
    chk("rhold_res_valid", {31'b0, res_valid}, 0);
    chk("rhold_stall_rst", {31'b0, stall}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rhold_after_res_valid", {31'b0, res_valid}, 0);
    end

    chk("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
